mdio_mgmt_controller: RTL and testbench

Clause-22 MDIO management master. It sequences PHY register reads and writes on the TSE MDIO pins (mdc, mdio_out, mdio_oen, mdio_in) on behalf of board-level logic such as PHY bring-up and link polling. Commands enter through a valid/ready port; each completed frame returns one response pulse. The outputs feed the top-level tristate, where mdio_oen low means the FPGA drives the pin.

---
 rtl/mdio_mgmt_controller.sv | 164 ++++++++++++++++
 tb/tb_mdio_mgmt_controller.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_mgmt_controller.sv
// Clause-22 MDIO management master: one read or write frame per command.
// MDC and MDIO are registered; mdio_oen low means the FPGA drives the pin.
module mdio_mgmt_controller #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wr_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        mdio_in
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    HDR,
    TA,
    DATA
  } state_t;

  localparam logic [7:0] DIV_MAX   = 8'(CLK_DIV - 1);
  localparam logic [5:0] PRE_CELLS = 6'(PREAMBLE_LEN);

  state_t      state;
  state_t      nxt_state;
  logic [7:0]  div;
  logic [5:0]  cnt;
  logic [5:0]  nxt_cnt;
  logic [31:0] shreg;
  logic [15:0] rd;
  logic        is_wr;
  logic        launch;
  logic        ta_bad;
  logic        cell_end;
  logic        accept;
  logic        drive;

  assign cell_end = mdc && (div == DIV_MAX);
  assign accept   = cmd_valid && cmd_ready
                 && (state == IDLE);
  assign drive    = (nxt_state == PRE)
                 || (nxt_state == HDR) || is_wr;

  // cnt holds the cells left in the current state, including this one
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt - 6'd1;
    if (launch) begin
      nxt_cnt = cnt;
    end else if (cnt == 6'd1) begin
      unique case (state)
        PRE: begin
          nxt_state = HDR;
          nxt_cnt   = 6'd14;
        end
        HDR: begin
          nxt_state = TA;
          nxt_cnt   = 6'd2;
        end
        TA: begin
          nxt_state = DATA;
          nxt_cnt   = 6'd16;
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      div       <= 8'd0;
      cnt       <= 6'd0;
      shreg     <= 32'd0;
      rd        <= 16'd0;
      is_wr     <= 1'b0;
      launch    <= 1'b0;
      ta_bad    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      mdc       <= 1'b0;
      mdio_out  <= 1'b1;
      mdio_oen  <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        mdc      <= 1'b0;
        mdio_out <= 1'b1;
        mdio_oen <= 1'b1;
        div      <= 8'd0;
        if (accept) begin
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          launch    <= 1'b1;
          is_wr     <= cmd_write;
          rd        <= 16'd0;
          ta_bad    <= 1'b0;
          state     <= (PREAMBLE_LEN > 0) ? PRE : HDR;
          cnt       <= (PREAMBLE_LEN > 0) ? PRE_CELLS
                                          : 6'd14;
          // reads carry all-ones after the header: the pin is released
          shreg <= cmd_write
            ? {2'b01, 2'b01, cmd_phy_addr,
               cmd_reg_addr, 2'b10, cmd_wr_data}
            : {2'b01, 2'b10, cmd_phy_addr,
               cmd_reg_addr, 18'h3FFFF};
        end else begin
          cmd_ready <= 1'b1;
        end
      end else if (launch || cell_end) begin
        launch <= 1'b0;
        div    <= 8'd0;
        mdc    <= 1'b0;
        state  <= nxt_state;
        cnt    <= nxt_cnt;
        if (nxt_state == IDLE) begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_data  <= is_wr ? 16'd0 : rd;
          rsp_err   <= !is_wr && ta_bad;
          mdio_out  <= 1'b1;
          mdio_oen  <= 1'b1;
        end else begin
          mdio_oen <= !drive;
          if (nxt_state == PRE) begin
            mdio_out <= 1'b1;
          end else begin
            mdio_out <= drive ? shreg[31] : 1'b1;
            shreg    <= {shreg[30:0], 1'b0};
          end
        end
      end else if (div == DIV_MAX) begin
        div <= 8'd0;
        mdc <= 1'b1;
        if (!is_wr && state == TA && cnt == 6'd1)
          ta_bad <= mdio_in;
        if (!is_wr && state == DATA)
          rd <= {rd[14:0], mdio_in};
      end else begin
        div <= div + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mdio_mgmt_controller.sv
// Bench for mdio_mgmt_controller: two configurations checked against
// a frame-level model and a cell-indexed PHY responder.
module tb_mdio_mgmt_controller;

  localparam int DIV_A = 2;
  localparam int PRE_A = 32;
  localparam int DIV_B = 1;
  localparam int PRE_B = 0;
  localparam int LAT_A = (PRE_A + 32) * 2 * DIV_A + 1;
  localparam int LAT_B = (PRE_B + 32) * 2 * DIV_B + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr = 1'b0;
  logic [4:0] phy = '0;
  logic [4:0] rg = '0;
  logic [15:0] wd = '0;

  logic va = 1'b0, ra, rva, rea, busya, mdca, outa, oena;
  logic ina;
  logic [15:0] rda;
  logic vb = 1'b0, rb, rvb, reb, busyb, mdcb, outb, oenb;
  logic [15:0] rdb;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int cells_a = 0, cells_b = 0, base_a = 0, base_b = 0;
  int rsp_cnt_a = 0;
  logic [63:0] got_out_a = '0, got_oen_a = '0;
  logic [63:0] got_out_b = '0, got_oen_b = '0;
  bit phy_on = 0;
  logic [15:0] phy_word = '0;

  always #5 clk = ~clk;

  mdio_mgmt_controller #(.CLK_DIV(DIV_A), .PREAMBLE_LEN(PRE_A)) u_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(va), .cmd_ready(ra), .cmd_write(wr),
    .cmd_phy_addr(phy), .cmd_reg_addr(rg), .cmd_wr_data(wd),
    .rsp_valid(rva), .rsp_data(rda), .rsp_err(rea), .busy(busya),
    .mdc(mdca), .mdio_out(outa), .mdio_oen(oena), .mdio_in(ina)
  );

  mdio_mgmt_controller #(.CLK_DIV(DIV_B), .PREAMBLE_LEN(PRE_B)) u_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(vb), .cmd_ready(rb), .cmd_write(wr),
    .cmd_phy_addr(phy), .cmd_reg_addr(rg), .cmd_wr_data(wd),
    .rsp_valid(rvb), .rsp_data(rdb), .rsp_err(reb), .busy(busyb),
    .mdc(mdcb), .mdio_out(outb), .mdio_oen(oenb), .mdio_in(1'b1)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // PHY bit presented for frame cell c (preamble of A is 32 cells)
  function automatic logic phy_bit(int c);
    int r;
    r = c - PRE_A;
    if (!phy_on) return 1'b1;
    if (r == 15) return 1'b0;
    if (r >= 16 && r <= 31) return phy_word[31 - r];
    return 1'b1;
  endfunction

  function automatic logic [63:0] model_out(int pre, logic w,
      logic [4:0] p, logic [4:0] r, logic [15:0] d);
    logic [31:0] body;
    logic [63:0] ones;
    body = w ? {2'b01, 2'b01, p, r, 2'b10, d}
             : {2'b01, 2'b10, p, r, 18'h3FFFF};
    ones = (64'd1 << pre) - 64'd1;
    return (ones << 32) | {32'd0, body};
  endfunction

  function automatic logic [63:0] model_oen(logic w);
    return w ? 64'd0 : 64'h3FFFF;
  endfunction

  initial begin
    logic pm;
    pm = 1'b0;
    ina = 1'b1;
    forever begin
      @(negedge clk);
      if (mdca && !pm) begin
        got_out_a = {got_out_a[62:0], outa};
        got_oen_a = {got_oen_a[62:0], oena};
        cells_a++;
      end
      pm = mdca;
      if (rva) rsp_cnt_a++;
      ina = phy_bit(cells_a - base_a);
    end
  end

  initial begin
    logic pm;
    pm = 1'b0;
    forever begin
      @(negedge clk);
      if (mdcb && !pm) begin
        got_out_b = {got_out_b[62:0], outb};
        got_oen_b = {got_oen_b[62:0], oenb};
        cells_b++;
      end
      pm = mdcb;
    end
  end

  task automatic run_a(input logic w, input logic [4:0] p,
      input logic [4:0] r, input logic [15:0] d, output int lat);
    int c0;
    int n;
    lat = -1;
    base_a = cells_a;
    @(negedge clk);
    n = 0;
    while (!ra && n < 50) begin
      @(negedge clk);
      n++;
    end
    wr = w; phy = p; rg = r; wd = d; va = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    va = 1'b0;
    n = 0;
    while (!rva && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rva) lat = cyc - c0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++;
    if ({mdca, outa, oena, rva, busya, rea} !== 6'b011000) begin
      $display("FAIL reset_pins got=%b want=011000",
               {mdca, outa, oena, rva, busya, rea});
    end else n_pass++;
    n_checks++;
    if (rda !== 16'h0000) begin
      $display("FAIL reset_rsp_data got=%h want=0000", rda);
    end else n_pass++;
    n_checks++;
    if ({mdcb, oenb, busyb} !== 3'b010) begin
      $display("FAIL reset_b got=%b want=010", {mdcb, oenb, busyb});
    end else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ra, rb} !== 2'b11) begin
      $display("FAIL reset_ready got=%b want=11", {ra, rb});
    end else n_pass++;
  endtask

  task automatic test_frames();
    logic w;
    logic [4:0] p, r;
    logic [15:0] d, ed;
    logic ee;
    int lat;
    for (int i = 0; i < 7; i++) begin
      w = 1'($urandom);
      p = 5'($urandom);
      r = 5'($urandom);
      d = 16'($urandom);
      phy_on = 1'($urandom);
      phy_word = 16'($urandom);
      if (i == 0) begin
        w = 1'b1; p = 5'h01; r = 5'h00; d = 16'h1140; phy_on = 0;
      end else if (i == 1) begin
        w = 1'b0; p = 5'h1F; r = 5'h02; phy_on = 1;
        phy_word = 16'h0141;
      end else if (i == 2) begin
        w = 1'b0; phy_on = 0;
      end
      ed = w ? 16'h0000 : (phy_on ? phy_word : 16'hFFFF);
      ee = !w && !phy_on;
      run_a(w, p, r, d, lat);
      n_checks++;
      if (lat !== LAT_A) begin
        $display("FAIL frame%0d_latency got=%0d want=%0d", i, lat, LAT_A);
      end else n_pass++;
      n_checks++;
      if (cells_a - base_a !== 64) begin
        $display("FAIL frame%0d_cells got=%0d want=64", i,
                 cells_a - base_a);
      end else n_pass++;
      n_checks++;
      if (got_out_a !== model_out(PRE_A, w, p, r, d)) begin
        $display("FAIL frame%0d_bits got=%h want=%h", i, got_out_a,
                 model_out(PRE_A, w, p, r, d));
      end else n_pass++;
      n_checks++;
      if (got_oen_a !== model_oen(w)) begin
        $display("FAIL frame%0d_oen got=%h want=%h", i, got_oen_a,
                 model_oen(w));
      end else n_pass++;
      n_checks++;
      if ({rda, rea} !== {ed, ee}) begin
        $display("FAIL frame%0d_rsp got=%h/%b want=%h/%b", i,
                 rda, rea, ed, ee);
      end else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({rva, busya, ra} !== 3'b001) begin
        $display("FAIL frame%0d_pulse got=%b want=001", i,
                 {rva, busya, ra});
      end else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [4:0] p, r;
    logic [15:0] d;
    int c0, n, lat, start;
    phy_on = 0;
    p = 5'($urandom);
    r = 5'($urandom);
    d = 16'($urandom);
    base_a = cells_a;
    start = rsp_cnt_a;
    lat = -1;
    @(negedge clk);
    wr = 1'b1; phy = p; rg = r; wd = d; va = 1'b1;
    c0 = cyc + 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      va = 1'($urandom);
      wr = 1'($urandom);
      phy = 5'($urandom);
      rg = 5'($urandom);
      wd = 16'($urandom);
    end
    va = 1'b0;
    n = 0;
    while (!rva && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rva) lat = cyc - c0;
    n_checks++;
    if (lat !== LAT_A) begin
      $display("FAIL busy_latency got=%0d want=%0d", lat, LAT_A);
    end else n_pass++;
    n_checks++;
    if (got_out_a !== model_out(PRE_A, 1'b1, p, r, d)) begin
      $display("FAIL busy_bits got=%h want=%h", got_out_a,
               model_out(PRE_A, 1'b1, p, r, d));
    end else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++;
    if (rsp_cnt_a - start !== 1) begin
      $display("FAIL busy_rsp_count got=%0d want=1", rsp_cnt_a - start);
    end else n_pass++;
  endtask

  task automatic test_midframe_reset();
    logic [4:0] p, r;
    logic [15:0] d;
    int n, lat;
    phy_on = 1;
    phy_word = 16'($urandom);
    base_a = cells_a;
    @(negedge clk);
    wr = 1'b0; phy = 5'($urandom); rg = 5'($urandom); va = 1'b1;
    @(negedge clk);
    va = 1'b0;
    n = 0;
    while (cells_a - base_a < PRE_A + 21 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (cells_a - base_a < PRE_A + 21) begin
      $display("FAIL midreset_reach got=%0d want=%0d",
               cells_a - base_a, PRE_A + 21);
    end else n_pass++;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({mdca, oena, busya, rva, outa} !== 5'b01001) begin
      $display("FAIL midreset_pins got=%b want=01001",
               {mdca, oena, busya, rva, outa});
    end else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ra !== 1'b1) begin
      $display("FAIL midreset_ready got=%b want=1", ra);
    end else n_pass++;
    phy_on = 0;
    p = 5'($urandom);
    r = 5'($urandom);
    d = 16'($urandom);
    run_a(1'b1, p, r, d, lat);
    n_checks++;
    if (lat !== LAT_A) begin
      $display("FAIL midreset_latency got=%0d want=%0d", lat, LAT_A);
    end else n_pass++;
    n_checks++;
    if (got_out_a !== model_out(PRE_A, 1'b1, p, r, d)) begin
      $display("FAIL midreset_bits got=%h want=%h", got_out_a,
               model_out(PRE_A, 1'b1, p, r, d));
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] p1, r1, p2, r2;
    logic [15:0] d1, d2;
    logic [63:0] e1, e2;
    int c0, c1, n, lat;
    p1 = 5'($urandom); r1 = 5'($urandom); d1 = 16'($urandom);
    p2 = 5'($urandom); r2 = 5'($urandom); d2 = 16'($urandom);
    e1 = model_out(PRE_B, 1'b1, p1, r1, d1);
    e2 = model_out(PRE_B, 1'b1, p2, r2, d2);
    base_b = cells_b;
    @(negedge clk);
    wr = 1'b1; phy = p1; rg = r1; wd = d1; vb = 1'b1;
    c0 = cyc + 1;
    @(negedge clk);
    phy = p2; rg = r2; wd = d2;
    n = 0;
    lat = -1;
    while (!rvb && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (rvb) lat = cyc - c0;
    n_checks++;
    if (lat !== LAT_B) begin
      $display("FAIL b2b_latency1 got=%0d want=%0d", lat, LAT_B);
    end else n_pass++;
    n_checks++;
    if (got_out_b[31:0] !== e1[31:0] || got_oen_b[31:0] !== 32'd0) begin
      $display("FAIL b2b_bits1 got=%h/%h want=%h/0", got_out_b[31:0],
               got_oen_b[31:0], e1[31:0]);
    end else n_pass++;
    n_checks++;
    if (rb !== 1'b1) begin
      $display("FAIL b2b_ready got=%b want=1", rb);
    end else n_pass++;
    base_b = cells_b;
    @(negedge clk);
    vb = 1'b0;
    c1 = cyc;
    n_checks++;
    if ({busyb, mdcb, oenb, rvb} !== 4'b1010) begin
      $display("FAIL b2b_gap got=%b want=1010", {busyb, mdcb, oenb, rvb});
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({outb, oenb, mdcb} !== 3'b000) begin
      $display("FAIL b2b_st got=%b want=000", {outb, oenb, mdcb});
    end else n_pass++;
    n = 0;
    lat = -1;
    while (!rvb && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (rvb) lat = cyc - c1;
    n_checks++;
    if (lat !== LAT_B) begin
      $display("FAIL b2b_latency2 got=%0d want=%0d", lat, LAT_B);
    end else n_pass++;
    n_checks++;
    if (got_out_b[31:0] !== e2[31:0] || cells_b - base_b !== 32) begin
      $display("FAIL b2b_bits2 got=%h/%0d want=%h/32", got_out_b[31:0],
               cells_b - base_b, e2[31:0]);
    end else n_pass++;
    n_checks++;
    if ({rdb, reb} !== 17'd0) begin
      $display("FAIL b2b_rsp got=%h/%b want=0000/0", rdb, reb);
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_busy_ignore();
    test_midframe_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
